// File: rtl/memory_access_if.sv
// Bundle of EX-stage inputs, data-memory req/ack port and registered WB outputs for the MEM stage.
// Pure wiring, no latency of its own.
// Backpressure is carried by o_stall and by the i_dmem_ack handshake.
interface memory_access_if;
    // EX -> MEM
    logic [31:0] i_result;
    logic [31:0] i_data_store;
    logic [31:0] i_pc;
    logic [2:0]  i_func3;
    logic [6:0]  i_opcode;
    logic [4:0]  i_rd;
    // MEM <-> data memory
    logic        o_dmem_req;
    logic        o_dmem_we;
    logic [31:0] o_dmem_addr;
    logic [3:0]  o_dmem_be;
    logic [31:0] o_dmem_wdata;
    logic        i_dmem_ack;
    logic [31:0] i_dmem_rdata;
    // MEM -> WB / hazard control
    logic [31:0] o_wb_data;
    logic [4:0]  o_wb_rd;
    logic        o_wb_en;
    logic [31:0] o_pc;
    logic        o_stall;
    logic        o_mem_exc;

    // The MEM stage itself
    modport master (
        input  i_result, i_data_store, i_pc, i_func3, i_opcode, i_rd,
        input  i_dmem_ack, i_dmem_rdata,
        output o_dmem_req, o_dmem_we, o_dmem_addr, o_dmem_be, o_dmem_wdata,
        output o_wb_data, o_wb_rd, o_wb_en, o_pc, o_stall, o_mem_exc
    );

    // Surrounding pipeline and data memory
    modport slave (
        output i_result, i_data_store, i_pc, i_func3, i_opcode, i_rd,
        output i_dmem_ack, i_dmem_rdata,
        input  o_dmem_req, o_dmem_we, o_dmem_addr, o_dmem_be, o_dmem_wdata,
        input  o_wb_data, o_wb_rd, o_wb_en, o_pc, o_stall, o_mem_exc
    );
endinterface

// File: rtl/memory_access.sv
// RV32I MEM stage: issues loads/stores on a req/ack port, aligns/extends data, registers the WB bundle.
// Latency: 1 cycle for non-memory ops and exceptions, 3+ cycles for loads/stores (IDLE, ACCESS.., DONE).
// Backpressure: o_stall holds IF/ID/EX while a legal access is being issued or is outstanding.
module memory_access #(
    parameter logic [6:0] OP_LOAD   = 7'b0000011,
    parameter logic [6:0] OP_STORE  = 7'b0100011,
    parameter logic [6:0] OP_BRANCH = 7'b1100011
) (
    input  logic               clk,
    input  logic               rst_n,
    memory_access_if.master    bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t      state_q;

    // Registered outputs
    logic        dmem_req_q;
    logic        dmem_we_q;
    logic [31:0] dmem_addr_q;
    logic [3:0]  dmem_be_q;
    logic [31:0] dmem_wdata_q;
    logic [31:0] wb_data_q;
    logic [4:0]  wb_rd_q;
    logic        wb_en_q;
    logic [31:0] pc_q;
    logic        mem_exc_q;

    // Context of the in-flight access, latched when it leaves IDLE
    logic        acc_load_q;
    logic [2:0]  acc_func3_q;
    logic [1:0]  acc_lane_q;
    logic [31:0] acc_result_q;
    logic [4:0]  acc_rd_q;
    logic [31:0] acc_pc_q;
    logic        acc_wb_en_q;
    logic [31:0] ld_data_q;

    // Decode of the instruction currently presented by EX
    logic        is_load;
    logic        is_store;
    logic [1:0]  lane;
    logic        f3_legal;
    logic        misalign;
    logic        mem_ok;
    logic        mem_exc_d;
    logic        wb_en_d;
    logic [3:0]  be_d;
    logic [31:0] wdata_d;
    logic [31:0] ld_shift;
    logic [15:0] ld_half;
    logic [31:0] ld_data_d;

    // Classify the EX instruction: memory op, legality, alignment and rd write enable
    always_comb begin
        is_load  = (bus.i_opcode == OP_LOAD);
        is_store = (bus.i_opcode == OP_STORE);
        lane     = bus.i_result[1:0];
        f3_legal = 1'b0;
        misalign = 1'b0;
        case (bus.i_func3)
            3'b000: f3_legal = 1'b1;
            3'b001: begin
                f3_legal = 1'b1;
                misalign = lane[0];
            end
            3'b010: begin
                f3_legal = 1'b1;
                misalign = |lane;
            end
            3'b100: f3_legal = is_load;
            3'b101: begin
                f3_legal = is_load;
                misalign = lane[0];
            end
            default: f3_legal = 1'b0;
        endcase
        mem_ok    = (is_load || is_store) && f3_legal && !misalign;
        mem_exc_d = (is_load || is_store) && !(f3_legal && !misalign);
        wb_en_d   = !((bus.i_opcode == OP_STORE) || (bus.i_opcode == OP_BRANCH) ||
                      (bus.i_opcode == 7'b0)) && (bus.i_rd != 5'd0);
    end

    // Byte enables and lane-replicated write data; the width code is func3[1:0] for loads and stores alike
    always_comb begin
        be_d    = 4'b1111;
        wdata_d = bus.i_data_store;
        case (bus.i_func3[1:0])
            2'b00: begin
                be_d    = 4'b0001 << lane;
                wdata_d = {4{bus.i_data_store[7:0]}};
            end
            2'b01: begin
                be_d    = lane[1] ? 4'b1100 : 4'b0011;
                wdata_d = {2{bus.i_data_store[15:0]}};
            end
            default: begin
                be_d    = 4'b1111;
                wdata_d = bus.i_data_store;
            end
        endcase
    end

    // Pick the addressed byte/half out of the read word and sign- or zero-extend it
    always_comb begin
        ld_shift  = bus.i_dmem_rdata >> {acc_lane_q, 3'b000};
        ld_half   = acc_lane_q[1] ? bus.i_dmem_rdata[31:16] : bus.i_dmem_rdata[15:0];
        ld_data_d = bus.i_dmem_rdata;
        case (acc_func3_q)
            3'b000:  ld_data_d = {{24{ld_shift[7]}}, ld_shift[7:0]};
            3'b001:  ld_data_d = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_data_d = {24'd0, ld_shift[7:0]};
            3'b101:  ld_data_d = {16'd0, ld_half};
            default: ld_data_d = bus.i_dmem_rdata;
        endcase
    end

    // Access FSM with registered memory-port and WB outputs; reset drops any outstanding request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            dmem_req_q   <= 1'b0;
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= 32'd0;
            dmem_be_q    <= 4'd0;
            dmem_wdata_q <= 32'd0;
            wb_data_q    <= 32'd0;
            wb_rd_q      <= 5'd0;
            wb_en_q      <= 1'b0;
            pc_q         <= 32'd0;
            mem_exc_q    <= 1'b0;
            acc_load_q   <= 1'b0;
            acc_func3_q  <= 3'd0;
            acc_lane_q   <= 2'd0;
            acc_result_q <= 32'd0;
            acc_rd_q     <= 5'd0;
            acc_pc_q     <= 32'd0;
            acc_wb_en_q  <= 1'b0;
            ld_data_q    <= 32'd0;
        end else begin
            mem_exc_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (mem_ok) begin
                        // Launch the access; WB registers keep their value while stalled
                        dmem_req_q   <= 1'b1;
                        dmem_we_q    <= is_store;
                        dmem_addr_q  <= {bus.i_result[31:2], 2'b00};
                        dmem_be_q    <= be_d;
                        dmem_wdata_q <= wdata_d;
                        acc_load_q   <= is_load;
                        acc_func3_q  <= bus.i_func3;
                        acc_lane_q   <= lane;
                        acc_result_q <= bus.i_result;
                        acc_rd_q     <= bus.i_rd;
                        acc_pc_q     <= bus.i_pc;
                        acc_wb_en_q  <= wb_en_d;
                        state_q      <= ACCESS;
                    end else begin
                        // Non-memory op or faulting access retires in one cycle
                        wb_data_q <= bus.i_result;
                        wb_rd_q   <= bus.i_rd;
                        wb_en_q   <= wb_en_d && !mem_exc_d;
                        pc_q      <= bus.i_pc;
                        mem_exc_q <= mem_exc_d;
                    end
                end
                ACCESS: begin
                    if (bus.i_dmem_ack) begin
                        dmem_req_q <= 1'b0;
                        ld_data_q  <= ld_data_d;
                        state_q    <= DONE;
                    end
                end
                DONE: begin
                    wb_data_q <= acc_load_q ? ld_data_q : acc_result_q;
                    wb_rd_q   <= acc_rd_q;
                    wb_en_q   <= acc_wb_en_q;
                    pc_q      <= acc_pc_q;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.o_dmem_req   = dmem_req_q;
    assign bus.o_dmem_we    = dmem_we_q;
    assign bus.o_dmem_addr  = dmem_addr_q;
    assign bus.o_dmem_be    = dmem_be_q;
    assign bus.o_dmem_wdata = dmem_wdata_q;
    assign bus.o_wb_data    = wb_data_q;
    assign bus.o_wb_rd      = wb_rd_q;
    assign bus.o_wb_en      = wb_en_q;
    assign bus.o_pc         = pc_q;
    assign bus.o_mem_exc    = mem_exc_q;
    // Stall is combinational so EX holds on the very cycle a legal access is seen
    assign bus.o_stall      = ((state_q == IDLE) && mem_ok) || (state_q == ACCESS);

endmodule

// File: tb/tb_memory_access.sv
// Directed bench for memory_access: ALU pass-through, loads/stores with varied ack timing,
// misaligned access, ack outside ACCESS, and asynchronous reset in the middle of an access.
module tb_memory_access;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_ALU   = 7'b0110011;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    memory_access_if bus ();

    memory_access dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [6:0] op, input logic [31:0] res, input logic [31:0] sd,
                         input logic [31:0] pc, input logic [2:0] f3, input logic [4:0] rd);
        bus.i_opcode     = op;
        bus.i_result     = res;
        bus.i_data_store = sd;
        bus.i_pc         = pc;
        bus.i_func3      = f3;
        bus.i_rd         = rd;
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        drive(7'b0, 32'd0, 32'd0, 32'd0, 3'd0, 5'd0);
        bus.i_dmem_ack   = 1'b0;
        bus.i_dmem_rdata = 32'd0;
        tick();
        tick();
        chk("rst_req",     {31'd0, bus.o_dmem_req}, 32'd0);
        chk("rst_wb_data", bus.o_wb_data, 32'd0);
        chk("rst_wb_en",   {31'd0, bus.o_wb_en}, 32'd0);
        chk("rst_stall",   {31'd0, bus.o_stall}, 32'd0);
        chk("rst_exc",     {31'd0, bus.o_mem_exc}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // ALU op retires in one cycle
        drive(OP_ALU, 32'h1234, 32'd0, 32'h40, 3'd0, 5'd5);
        #1;
        chk("alu_stall", {31'd0, bus.o_stall}, 32'd0);
        tick();
        chk("alu_wb_data", bus.o_wb_data, 32'h1234);
        chk("alu_wb_rd",   {27'd0, bus.o_wb_rd}, 32'd5);
        chk("alu_wb_en",   {31'd0, bus.o_wb_en}, 32'd1);
        chk("alu_pc",      bus.o_pc, 32'h40);

        // LB 0x103, ack on second ACCESS cycle
        drive(OP_LOAD, 32'h103, 32'd0, 32'h44, 3'b000, 5'd7);
        #1;
        chk("lb_stall_idle", {31'd0, bus.o_stall}, 32'd1);
        chk("lb_req_idle",   {31'd0, bus.o_dmem_req}, 32'd0);
        tick();
        chk("lb_req",        {31'd0, bus.o_dmem_req}, 32'd1);
        chk("lb_we",         {31'd0, bus.o_dmem_we}, 32'd0);
        chk("lb_addr",       bus.o_dmem_addr, 32'h100);
        chk("lb_stall_a1",   {31'd0, bus.o_stall}, 32'd1);
        tick();
        chk("lb_wb_hold",    bus.o_wb_data, 32'h1234);
        chk("lb_stall_a2",   {31'd0, bus.o_stall}, 32'd1);
        bus.i_dmem_ack   = 1'b1;
        bus.i_dmem_rdata = 32'h8000_0000;
        tick();
        bus.i_dmem_ack = 1'b0;
        chk("lb_req_done",   {31'd0, bus.o_dmem_req}, 32'd0);
        chk("lb_stall_done", {31'd0, bus.o_stall}, 32'd0);
        tick();
        chk("lb_wb_data",    bus.o_wb_data, 32'hFFFF_FF80);
        chk("lb_wb_rd",      {27'd0, bus.o_wb_rd}, 32'd7);
        chk("lb_wb_en",      {31'd0, bus.o_wb_en}, 32'd1);
        chk("lb_pc",         bus.o_pc, 32'h44);

        // SH 0x102 -> upper half lanes
        drive(OP_STORE, 32'h102, 32'h0000_ABCD, 32'h48, 3'b001, 5'd0);
        tick();
        chk("sh_req",   {31'd0, bus.o_dmem_req}, 32'd1);
        chk("sh_we",    {31'd0, bus.o_dmem_we}, 32'd1);
        chk("sh_be",    {28'd0, bus.o_dmem_be}, 32'hC);
        chk("sh_wdata", bus.o_dmem_wdata, 32'hABCD_ABCD);
        chk("sh_addr",  bus.o_dmem_addr, 32'h100);
        bus.i_dmem_ack = 1'b1;
        tick();
        bus.i_dmem_ack = 1'b0;
        tick();
        chk("sh_wb_en", {31'd0, bus.o_wb_en}, 32'd0);

        // SB 0x101 -> lane 1, byte replicated
        drive(OP_STORE, 32'h101, 32'h1234_565A, 32'h4C, 3'b000, 5'd0);
        tick();
        chk("sb_be",    {28'd0, bus.o_dmem_be}, 32'h2);
        chk("sb_wdata", bus.o_dmem_wdata, 32'h5A5A_5A5A);
        bus.i_dmem_ack = 1'b1;
        tick();
        bus.i_dmem_ack = 1'b0;
        tick();

        // Misaligned LW: exception pulse, no request, no stall
        drive(OP_LOAD, 32'h102, 32'd0, 32'h50, 3'b010, 5'd3);
        #1;
        chk("lw_mis_stall", {31'd0, bus.o_stall}, 32'd0);
        tick();
        chk("lw_mis_exc",   {31'd0, bus.o_mem_exc}, 32'd1);
        chk("lw_mis_req",   {31'd0, bus.o_dmem_req}, 32'd0);
        chk("lw_mis_wb_en", {31'd0, bus.o_wb_en}, 32'd0);
        chk("lw_mis_pc",    bus.o_pc, 32'h50);
        drive(7'b0, 32'd0, 32'd0, 32'h54, 3'd0, 5'd0);
        tick();
        chk("lw_mis_exc_end", {31'd0, bus.o_mem_exc}, 32'd0);
        chk("lw_mis_req_end", {31'd0, bus.o_dmem_req}, 32'd0);

        // LHU 0x200 with ack already high in IDLE (ignored) and in first ACCESS cycle
        drive(OP_LOAD, 32'h200, 32'd0, 32'h58, 3'b101, 5'd9);
        bus.i_dmem_ack   = 1'b1;
        bus.i_dmem_rdata = 32'h0000_F00F;
        tick();
        chk("lhu_req", {31'd0, bus.o_dmem_req}, 32'd1);
        tick();
        bus.i_dmem_ack = 1'b0;
        chk("lhu_req_done", {31'd0, bus.o_dmem_req}, 32'd0);
        tick();
        chk("lhu_wb_data", bus.o_wb_data, 32'h0000_F00F);
        chk("lhu_wb_rd",   {27'd0, bus.o_wb_rd}, 32'd9);

        // Back-to-back SW
        drive(OP_STORE, 32'h204, 32'hDEAD_BEEF, 32'h5C, 3'b010, 5'd0);
        #1;
        chk("sw_stall", {31'd0, bus.o_stall}, 32'd1);
        tick();
        chk("sw_req",   {31'd0, bus.o_dmem_req}, 32'd1);
        chk("sw_be",    {28'd0, bus.o_dmem_be}, 32'hF);
        chk("sw_wdata", bus.o_dmem_wdata, 32'hDEAD_BEEF);
        chk("sw_addr",  bus.o_dmem_addr, 32'h204);
        bus.i_dmem_ack = 1'b1;
        tick();
        bus.i_dmem_ack = 1'b0;
        tick();
        chk("sw_wb_en", {31'd0, bus.o_wb_en}, 32'd0);

        // Reset in the middle of an access
        drive(OP_LOAD, 32'h300, 32'd0, 32'h60, 3'b010, 5'd4);
        tick();
        chk("rst_mid_req_before", {31'd0, bus.o_dmem_req}, 32'd1);
        #1;
        rst_n = 1'b0;
        drive(7'b0, 32'd0, 32'd0, 32'd0, 3'd0, 5'd0);
        #1;
        chk("rst_mid_req",     {31'd0, bus.o_dmem_req}, 32'd0);
        chk("rst_mid_wb_data", bus.o_wb_data, 32'd0);
        chk("rst_mid_addr",    bus.o_dmem_addr, 32'd0);
        chk("rst_mid_stall",   {31'd0, bus.o_stall}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Clean LW after reset release, ack in first ACCESS cycle
        drive(OP_LOAD, 32'h300, 32'd0, 32'h60, 3'b010, 5'd4);
        tick();
        chk("lw_req",  {31'd0, bus.o_dmem_req}, 32'd1);
        chk("lw_addr", bus.o_dmem_addr, 32'h300);
        bus.i_dmem_ack   = 1'b1;
        bus.i_dmem_rdata = 32'h1234_5678;
        tick();
        bus.i_dmem_ack = 1'b0;
        tick();
        drive(7'b0, 32'd0, 32'd0, 32'd0, 3'd0, 5'd0);
        chk("lw_wb_data", bus.o_wb_data, 32'h1234_5678);
        chk("lw_wb_rd",   {27'd0, bus.o_wb_rd}, 32'd4);
        chk("lw_wb_en",   {31'd0, bus.o_wb_en}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
